// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: merges the instruction-cache and data-cache AXI read
// channels onto one master read port. One transaction is in flight at a time;
// the grant is held until the last R beat is accepted, and ties alternate.
module axi_read_arbiter #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  // instruction cache side
  input  logic [31:0] inst_araddr,
  input  logic [7:0]  inst_arlen,
  input  logic        inst_arvalid,
  output logic        inst_arready,
  output logic [31:0] inst_rdata,
  output logic        inst_rlast,
  output logic        inst_rvalid,
  input  logic        inst_rready,
  // data cache side
  input  logic [31:0] data_araddr,
  input  logic [7:0]  data_arlen,
  input  logic        data_arvalid,
  output logic        data_arready,
  output logic [31:0] data_rdata,
  output logic        data_rlast,
  output logic        data_rvalid,
  input  logic        data_rready,
  // master read port
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_INST = 2'd1,
    GRANT_DATA = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   ar_done_q, ar_done_d;   // AR of the current grant already accepted
  logic   last_data_q, last_data_d; // previous transaction served the data side
  logic   r_last_hs;
  logic   unused_s;

  // Only one transaction is ever outstanding, so rid/rresp carry no routing info.
  assign unused_s  = ^{rid, rresp};
  assign r_last_hs = rvalid & rready & rlast;

  assign arsize     = 3'b010;
  assign arburst    = 2'b01;
  assign inst_rdata = rdata;
  assign inst_rlast = rlast;
  assign data_rdata = rdata;
  assign data_rlast = rlast;

  // Register grant state, AR-issued flag and the fairness bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ar_done_q   <= 1'b0;
      last_data_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      ar_done_q   <= ar_done_d;
      last_data_q <= last_data_d;
    end
  end

  // Arbitrate in IDLE; in a grant, track the AR handshake and release on rlast.
  always_comb begin
    state_d     = state_q;
    ar_done_d   = ar_done_q;
    last_data_d = last_data_q;
    case (state_q)
      IDLE: begin
        ar_done_d = 1'b0;
        if (inst_arvalid && data_arvalid) begin
          // Tie: serve whichever side did not get the previous transaction.
          state_d = last_data_q ? GRANT_INST : GRANT_DATA;
        end else if (inst_arvalid) begin
          state_d = GRANT_INST;
        end else if (data_arvalid) begin
          state_d = GRANT_DATA;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_INST, GRANT_DATA: begin
        if (r_last_hs) begin
          state_d     = IDLE;
          ar_done_d   = 1'b0;
          last_data_d = (state_q == GRANT_DATA);
        end else if (arvalid && arready) begin
          ar_done_d = 1'b1;
        end else begin
          ar_done_d = ar_done_q;
        end
      end
      default: begin
        state_d   = IDLE;
        ar_done_d = 1'b0;
      end
    endcase
  end

  // Steer AR and R handshakes to and from the granted side only.
  always_comb begin
    araddr       = 32'd0;
    arlen        = 8'd0;
    arid         = 4'd0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    inst_arready = 1'b0;
    data_arready = 1'b0;
    inst_rvalid  = 1'b0;
    data_rvalid  = 1'b0;
    case (state_q)
      GRANT_INST: begin
        araddr       = inst_araddr;
        arlen        = inst_arlen;
        arid         = ID_INST;
        arvalid      = inst_arvalid & ~ar_done_q;
        inst_arready = arready & ~ar_done_q;
        inst_rvalid  = rvalid & ar_done_q;
        rready       = inst_rready & ar_done_q;
      end
      GRANT_DATA: begin
        araddr       = data_araddr;
        arlen        = data_arlen;
        arid         = ID_DATA;
        arvalid      = data_arvalid & ~ar_done_q;
        data_arready = arready & ~ar_done_q;
        data_rvalid  = rvalid & ar_done_q;
        rready       = data_rready & ar_done_q;
      end
      default: begin
        arvalid = 1'b0;
        rready  = 1'b0;
      end
    endcase
  end

endmodule
